// File: rtl/ahb_bus_arbiter_if.sv
// AHB arbitration bundle between requesting masters and the bus arbiter.
// master modport is the requester side, slave modport is the arbiter side.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with burst/lock tracking and default-master parking.
// Define ARB_HOLD_TIMEOUT_EN to bound undefined-INCR ownership to MAX_HOLD edges.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 32
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_bus_arbiter_if.slave bus
);
  localparam int MW = $clog2(NUM_MASTERS);
  typedef logic [MW-1:0] idx_t;
  typedef logic [NUM_MASTERS-1:0] vec_t;

  localparam idx_t DEF = idx_t'(DEFAULT_MASTER);
  localparam vec_t ONE = vec_t'(1);

  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_INCR   = 3'b001;

  idx_t       gidx_q;
  vec_t       grant_q;
  idx_t       hmaster_q;
  logic       hmastlock_q;
  logic [3:0] rem_q, rem_d;
  logic       incr_q, incr_d;

  logic is_nonseq, is_seq, is_busy;
  logic undef, lock_hold, burst_hold, incr_hold;
  logic others, tmo, hold;
  idx_t gnext;

  function automatic idx_t rr_pick(
    input idx_t g,
    input vec_t req
  );
    idx_t r;
    logic hit;
    r   = DEF;
    hit = 1'b0;
    // g+1 .. g-1 first, g itself last
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      int j;
      j = (int'(g) + i) % NUM_MASTERS;
      if (!hit && req[j]) begin
        r   = idx_t'(j);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  assign is_nonseq = bus.HTRANS == T_NONSEQ;
  assign is_seq    = bus.HTRANS == T_SEQ;
  assign is_busy   = bus.HTRANS == T_BUSY;

  always_comb begin
    rem_d  = rem_q;
    incr_d = incr_q;
    unique case (1'b1)
      is_nonseq: begin
        incr_d = bus.HBURST == B_INCR;
        unique case (bus.HBURST)
          3'b010, 3'b011: rem_d = 4'd3;
          3'b100, 3'b101: rem_d = 4'd7;
          3'b110, 3'b111: rem_d = 4'd15;
          default:        rem_d = 4'd0;
        endcase
      end
      is_seq: rem_d = (rem_q != 4'd0) ? rem_q - 4'd1 : 4'd0;
      default: ;
    endcase
  end

  assign undef = (is_nonseq && bus.HBURST == B_INCR)
              || (incr_q && (is_seq || is_busy));

  assign lock_hold  = bus.HLOCK[gidx_q];
  assign burst_hold = rem_d > 4'd1;
  assign incr_hold  = undef && bus.HBUSREQ[gidx_q];
  assign others     = |(bus.HBUSREQ & ~(ONE << gidx_q));

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int TW = $clog2(MAX_HOLD + 1);
  localparam logic [TW-1:0] TLIM = TW'(MAX_HOLD - 1);

  logic [TW-1:0] timer_q;
  logic          incr_only;

  assign incr_only = incr_hold && !lock_hold && !burst_hold;
  assign tmo       = incr_only && others && timer_q == TLIM;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      timer_q <= '0;
    end else if (bus.HREADY) begin
      if (gnext != gidx_q)
        timer_q <= '0;
      else if (incr_only && timer_q != TLIM)
        timer_q <= timer_q + TW'(1);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign hold  = (lock_hold || burst_hold || incr_hold) && !tmo;
  assign gnext = hold ? gidx_q : rr_pick(gidx_q, bus.HBUSREQ);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gidx_q      <= DEF;
      grant_q     <= ONE << DEF;
      hmaster_q   <= DEF;
      hmastlock_q <= 1'b0;
      rem_q       <= 4'd0;
      incr_q      <= 1'b0;
    end else if (bus.HREADY) begin
      gidx_q      <= gnext;
      grant_q     <= ONE << gnext;
      hmaster_q   <= gidx_q;
      hmastlock_q <= bus.HLOCK[gidx_q];
      rem_q       <= rem_d;
      incr_q      <= incr_d;
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed vectors, queued expectations.
// Expected timeout behaviour follows ARB_HOLD_TIMEOUT_EN when defined.
module tb_ahb_bus_arbiter;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSQ  = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;
  localparam logic [2:0] SGL  = 3'b000;
  localparam logic [2:0] INC  = 3'b001;
  localparam logic [2:0] INC4 = 3'b011;
  localparam logic [2:0] WR8  = 3'b100;
  localparam logic [2:0] I16  = 3'b111;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TMO = 1'b1;
  localparam int NH  = 32;
`else
  localparam bit TMO = 1'b0;
  localparam int NH  = 40;
`endif

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
    string      nm;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int nasserts = 0;
  int nfails = 0;
  exp_t sb[$];
  exp_t cur;

  ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS(4),
    .DEFAULT_MASTER(0),
    .MAX_HOLD(32)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(
    input string nm,
    input logic [7:0] act,
    input logic [7:0] req
  );
    nasserts++;
    if (act !== req) begin
      nfails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(posedge HCLK) begin
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk({cur.nm, "/grant"}, 8'(bus.HGRANT), 8'(cur.g));
      chk({cur.nm, "/hmaster"}, 8'(bus.HMASTER), 8'(cur.m));
      chk({cur.nm, "/hmastlock"}, 8'(bus.HMASTLOCK), 8'(cur.l));
      chk({cur.nm, "/onehot"}, 8'($countones(bus.HGRANT)), 8'd1);
    end
  end

  task automatic step(
    input logic       rst,
    input logic [3:0] req,
    input logic [3:0] lck,
    input logic [1:0] tr,
    input logic [2:0] bu,
    input logic       rdy,
    input logic [3:0] eg,
    input logic [1:0] em,
    input logic       el,
    input string      nm
  );
    exp_t e;
    @(negedge HCLK);
    HRESETn     = rst;
    bus.HBUSREQ = req;
    bus.HLOCK   = lck;
    bus.HTRANS  = tr;
    bus.HBURST  = bu;
    bus.HREADY  = rdy;
    e.g  = eg;
    e.m  = em;
    e.l  = el;
    e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = IDLE;
    bus.HBURST  = SGL;
    bus.HREADY  = 1'b1;

    step(0, 4'b0000, 0, IDLE, SGL, 1, 4'b0001, 0, 0, "reset0");
    step(0, 4'b0000, 0, IDLE, SGL, 1, 4'b0001, 0, 0, "reset1");
    for (int i = 0; i < 10; i++)
      step(1, 4'b0000, 0, IDLE, SGL, 1, 4'b0001, 0, 0, "park");

    step(1, 4'b0110, 0, NSQ, SGL, 1, 4'b0010, 0, 0, "alt_a");
    step(1, 4'b0110, 0, NSQ, SGL, 1, 4'b0100, 1, 0, "alt_b");
    step(1, 4'b0110, 0, NSQ, SGL, 1, 4'b0010, 2, 0, "alt_c");
    step(1, 4'b0110, 0, NSQ, SGL, 1, 4'b0100, 1, 0, "alt_d");

    step(1, 4'b0010, 0, IDLE, SGL, 1, 4'b0010, 2, 0, "i4_gr");
    step(1, 4'b0010, 0, IDLE, SGL, 1, 4'b0010, 1, 0, "i4_own");
    step(1, 4'b0110, 0, NSQ, INC4, 1, 4'b0010, 1, 0, "i4_b1");
    step(1, 4'b0110, 0, SEQ, INC4, 1, 4'b0010, 1, 0, "i4_b2");
    step(1, 4'b0110, 0, SEQ, INC4, 1, 4'b0100, 1, 0, "i4_b3");
    step(1, 4'b0100, 0, SEQ, INC4, 1, 4'b0100, 2, 0, "i4_b4");

    step(1, 4'b0110, 0, NSQ, WR8, 1, 4'b0100, 2, 0, "w8_b1");
    step(1, 4'b0110, 0, SEQ, WR8, 1, 4'b0100, 2, 0, "w8_b2");
    step(1, 4'b0110, 0, SEQ, WR8, 1, 4'b0100, 2, 0, "w8_b3");
    for (int i = 0; i < 3; i++)
      step(1, 4'b0110, 0, SEQ, WR8, 0, 4'b0100, 2, 0, "w8_wait");
    step(1, 4'b0110, 0, SEQ, WR8, 1, 4'b0100, 2, 0, "w8_b4");
    step(1, 4'b0110, 0, SEQ, WR8, 1, 4'b0100, 2, 0, "w8_b5");
    step(1, 4'b0110, 0, SEQ, WR8, 1, 4'b0100, 2, 0, "w8_b6");
    step(1, 4'b0110, 0, SEQ, WR8, 1, 4'b0010, 2, 0, "w8_b7");
    step(1, 4'b0010, 0, SEQ, WR8, 1, 4'b0010, 1, 0, "w8_b8");

    step(1, 4'b1000, 4'b1000, IDLE, SGL, 1, 4'b1000, 1, 0, "lk_gr");
    for (int i = 0; i < 3; i++)
      step(1, 4'b1111, 4'b1000, NSQ, SGL, 1, 4'b1000, 3, 1, "lk_hold");
    step(1, 4'b1111, 4'b0000, IDLE, SGL, 1, 4'b0001, 3, 0, "lk_rel");
    step(1, 4'b0000, 4'b0000, IDLE, SGL, 1, 4'b0001, 0, 0, "lk_park");

    step(1, 4'b0011, 0, NSQ, I16, 1, 4'b0001, 0, 0, "rm_b1");
    step(1, 4'b0011, 0, SEQ, I16, 1, 4'b0001, 0, 0, "rm_b2");
    step(0, 4'b0011, 0, SEQ, I16, 1, 4'b0001, 0, 0, "rm_rst");
    step(1, 4'b0010, 0, IDLE, SGL, 1, 4'b0010, 0, 0, "rm_post");
    step(1, 4'b0000, 0, IDLE, SGL, 1, 4'b0001, 1, 0, "rm_park");
    step(1, 4'b0000, 0, IDLE, SGL, 1, 4'b0001, 0, 0, "rm_idle");

    step(1, 4'b0011, 0, NSQ, INC, 1, 4'b0001, 0, 0, "ui_k1");
    for (int k = 2; k <= NH; k++) begin
      if (TMO && k == 32)
        step(1, 4'b0011, 0, SEQ, INC, 1, 4'b0010, 0, 0, "ui_tmo");
      else
        step(1, 4'b0011, 0, SEQ, INC, 1, 4'b0001, 0, 0, "ui_hold");
    end
    step(1, 4'b0000, 0, IDLE, SGL, 1, 4'b0001, TMO ? 2'd1 : 2'd0, 0,
         "ui_end");
    step(1, 4'b0000, 0, IDLE, SGL, 1, 4'b0001, 0, 0, "ui_park");

    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(posedge HCLK);
    #2;
    if (sb.size() != 0) begin
      nfails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nasserts, nfails);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin AHB arbiter that shares the single slave-side bus, feeding the slave wrappers, between NUM_MASTERS requesting masters.
- Generates one-hot HGRANT and the address-phase owner index HMASTER (which drives the master mux) plus HMASTLOCK.
- Tracks fixed-length bursts and locked sequences so ownership never changes mid-burst.
- Parks the bus on DEFAULT_MASTER when idle.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- DEFAULT_MASTER, 0, index granted when no master requests; also the reset owner.
- MAX_HOLD, 32, cycle limit for undefined-length INCR ownership (used only with the optional feature).

Ports:
- HCLK  input  1  bus clock, all state on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HBUSREQ  input  NUM_MASTERS  per-master bus request.
- HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  input  2  muxed transfer type of the current address-phase owner.
- HBURST  input  3  muxed burst type of the current owner.
- HREADY  input  1  bus-wide ready (muxed HREADYOUT).
- HGRANT  output  NUM_MASTERS  one-hot grant, registered.
- HMASTER  output  $clog2(NUM_MASTERS)  index of the address-phase owner, registered.
- HMASTLOCK  output  1  current address phase is locked, registered.

Behaviour:
- Reset (HRESETn low, asynchronous):
  - HGRANT = 1<<DEFAULT_MASTER, HMASTER = DEFAULT_MASTER, HMASTLOCK = 0.
  - Beat counter rem = 0, RR pointer = DEFAULT_MASTER, hold timer = 0.
  - Reset mid-burst discards all burst state.
- Only edges where HREADY = 1 update any state. When HREADY = 0, all outputs and internal state are frozen.
- Beat counter (HREADY = 1 edges):
  - HTRANS = NONSEQ loads rem with beats-1, where beats = 4 for INCR4/WRAP4, 8 for INCR8/WRAP8, 16 for INCR16/WRAP16.
  - NONSEQ with SINGLE or INCR loads rem = 0.
  - SEQ decrements rem, saturating at 0.
  - IDLE and BUSY leave rem unchanged.
  - rem_next denotes the value after the current edge.
- Hold condition, evaluated per HREADY edge for granted master g. The grant is held if any of the following is true:
  - HLOCK[g] = 1.
  - rem_next > 1.
  - An undefined INCR is in progress (last NONSEQ had HBURST = INCR and HTRANS is SEQ/BUSY) and HBUSREQ[g] = 1.
- If hold is false, the grant moves to the first requesting master after g in circular order (g+1 .. g-1, then g itself).
  - If no master requests, the grant moves to DEFAULT_MASTER.
  - The RR pointer equals the last granted index.
- Handover timing:
  - rem_next = 1 allows re-grant during the last beat's address phase. HGRANT changes at edge N.
  - The new master drives its address at edge N+1, when HMASTER and HMASTLOCK take their new values.
- HMASTER and HMASTLOCK are updated on each HREADY = 1 edge from the previous cycle's HGRANT index and HLOCK[that index]. This gives one HREADY cycle of grant-to-ownership latency.
- An early burst termination (owner issues IDLE or NONSEQ before rem reaches 0) clears or reloads rem; arbitration then proceeds normally.
- Simultaneous requests are resolved by RR order only. A master whose HBUSREQ is dropped while it holds a fixed burst keeps the grant until the burst ends.
- HGRANT is always exactly one-hot.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- With the macro defined, a hold timer counts HREADY edges while g holds the bus via the undefined-INCR rule only.
  - On reaching MAX_HOLD with another master requesting, the hold condition is forced false and the grant rotates.
  - The timer clears on every grant change.
  - Locked and fixed-burst holds are never preempted.
- Without the macro, undefined INCR ownership is unbounded and the timer logic is absent.

Test Plan:
- Reset with HBUSREQ = 0 -> HGRANT = 0001, HMASTER = 0, HMASTLOCK = 0; still parked after 10 idle cycles.
- HBUSREQ = 0110 from idle with SINGLE transfers -> grants alternate 0010, 0100, 0010...; HMASTER lags HGRANT by one HREADY edge.
- M1 granted, issues INCR4 (NONSEQ + 3 SEQ) while M2 requests -> HGRANT stays 0010 until the edge where the 3rd beat is accepted (rem_next = 1), then 0100; HMASTER = 2 one edge later.
- HREADY held low for 3 cycles during a WRAP8 -> HGRANT, HMASTER and rem unchanged across the wait; handover still occurs after the 8th beat timing.
- M3 asserts HLOCK[3] with all masters requesting -> M3 retains grant for the whole locked sequence, HMASTLOCK = 1; rotates to M0 one edge after HLOCK drops.
- With ARB_HOLD_TIMEOUT_EN and MAX_HOLD = 32: M0 runs undefined INCR holding HBUSREQ while M1 requests -> grant rotates to M1 after exactly 32 HREADY edges. Without the macro -> M0 keeps the grant indefinitely.
